// File: rtl/alu_pkg.sv
// Shared ALU op encodings and default widths for the ALU arbiter slice.
package alu_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;
endpackage

// File: rtl/alu_rsp_slot.sv
// One requester's response register with valid/ready drain and a wrapping grant counter.
module alu_rsp_slot
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             grant,
  input  logic             rsp_ready,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] grant_cnt
);

  // A grant always wins over a drain, so a slot drained this cycle is refilled in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_out   <= '0;
      rsp_zero  <= 1'b0;
      grant_cnt <= '0;
    end else if (grant) begin
      rsp_valid <= 1'b1;
      rsp_out   <= alu_out;
      rsp_zero  <= alu_zero;
      grant_cnt <= grant_cnt + 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// with a registered response slot per requester.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid0,
  output logic             req_ready0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [1:0]       req_sel0,
  input  logic             req_valid1,
  output logic             req_ready1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [1:0]       req_sel1,
  output logic             rsp_valid0,
  input  logic             rsp_ready0,
  output logic [WIDTH-1:0] rsp_out0,
  output logic             rsp_zero0,
  output logic             rsp_valid1,
  input  logic             rsp_ready1,
  output logic [WIDTH-1:0] rsp_out1,
  output logic             rsp_zero1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  logic elig0, elig1;
  logic grant0, grant1;
  logic prio;

  // A full slot is still eligible if it drains this cycle.
  assign elig0 = req_valid0 && (!rsp_valid0 || rsp_ready0);
  assign elig1 = req_valid1 && (!rsp_valid1 || rsp_ready1);

  always_comb begin
    grant0 = elig0;
    grant1 = elig1;
    if (elig0 && elig1) begin
      grant0 = !prio;
      grant1 = prio;
    end
  end

  assign req_ready0 = grant0;
  assign req_ready1 = grant1;

  // Priority passes to whichever requester lost the last grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (grant0) begin
      prio <= 1'b1;
    end else if (grant1) begin
      prio <= 1'b0;
    end
  end

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = ALU_ADD;
    if (grant0) begin
      alu_a   = req_a0;
      alu_b   = req_b0;
      alu_sel = req_sel0;
    end else if (grant1) begin
      alu_a   = req_a1;
      alu_b   = req_b1;
      alu_sel = req_sel1;
    end
  end

  alu_rsp_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant0),
    .rsp_ready (rsp_ready0),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid0),
    .rsp_out   (rsp_out0),
    .rsp_zero  (rsp_zero0),
    .grant_cnt (grant_cnt0)
  );

  alu_rsp_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant1),
    .rsp_ready (rsp_ready1),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid1),
    .rsp_out   (rsp_out1),
    .rsp_zero  (rsp_zero1),
    .grant_cnt (grant_cnt1)
  );

endmodule
